// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Covers the hazards that forwarding cannot resolve:
//   - load-use
//   - operands of a compare-in-ID branch that are not ready yet
//   - taken branch/jump flush
//   - multi-cycle data-memory waits, guarded by a watchdog
// Control outputs are combinational from the state and the current inputs.
// Counters and the watchdog flag are registered.
module pipeline_hazard_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_branch_i,
  input  logic             id_jump_taken_i,
  input  logic             ex_memread_i,
  input  logic             ex_regwrite_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             mem_memread_i,
  input  logic [4:0]       mem_rd_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             backend_hold_o,
  output logic             wd_error_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       wd_set;

  logic ex_hit, mem_hit;
  logic lu, br_ex, br_mem, haz;
  logic mem_stall;

  // Register-match terms: $0 is hardwired and can never be a hazard source
  always_comb begin
    ex_hit  = (ex_rd_i  != 5'd0) && ((ex_rd_i  == id_rs_i) || (ex_rd_i  == id_rt_i));
    mem_hit = (mem_rd_i != 5'd0) && ((mem_rd_i == id_rs_i) || (mem_rd_i == id_rt_i));
    lu        = ex_memread_i & ex_hit;
    br_ex     = id_branch_i & ex_regwrite_i & ex_hit;
    br_mem    = id_branch_i & mem_memread_i & mem_hit;
    haz       = lu | br_ex | br_mem;
    mem_stall = dmem_req_i & ~dmem_ready_i;
  end

  // State register; reset returns to RUN immediately, even mid-wait
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next state and control outputs. Everything is forced low in reset so
  // that the front-end is held.
  always_comb begin
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    wd_set         = 1'b0;
    pc_write_o     = 1'b0;
    ifid_write_o   = 1'b0;
    ifid_flush_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    backend_hold_o = 1'b0;
    if (!rst_i) begin
      unique case (state)
        RUN: begin
          if (mem_stall) begin
            // Freeze the whole pipe until the memory answers
            backend_hold_o = 1'b1;
            state_nxt      = MEM_WAIT;
            wait_cnt_nxt   = 8'd1;
          end else if (haz) begin
            // Hold IF/ID and drop a bubble into EX. Any taken branch is
            // ignored here because its operands are not valid yet.
            idex_bubble_o = 1'b1;
          end else if (id_jump_taken_i) begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
            ifid_flush_o = 1'b1;
          end else begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
          end
        end
        MEM_WAIT: begin
          // ID is frozen as well, so a taken branch waiting there is
          // re-evaluated in RUN once the memory releases the pipe
          backend_hold_o = 1'b1;
          if (dmem_ready_i) begin
            state_nxt    = RUN;
            wait_cnt_nxt = 8'd0;
          end else if (wait_cnt == WAIT_LIMIT) begin
            state_nxt = HALT;
            wd_set    = 1'b1;
          end else begin
            wait_cnt_nxt = wait_cnt + 8'd1;
          end
        end
        HALT: begin
          backend_hold_o = 1'b1;
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  // Sticky watchdog flag; only reset clears it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       wd_error_o <= 1'b0;
    else if (wd_set) wd_error_o <= 1'b1;
  end

  // Saturating performance counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (!pc_write_o && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (ifid_flush_o && (flush_cnt_o != '1)) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed plan scenarios followed by
// randomized traffic, all checked against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 4;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic             clk, rst;
  logic [4:0]       id_rs, id_rt, ex_rd, mem_rd;
  logic             id_branch, id_jt, ex_memread, ex_regwrite, mem_memread;
  logic             dmem_req, dmem_ready;
  logic             pc_write, ifid_write, ifid_flush, idex_bubble, backend_hold, wd_error;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipeline_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_branch_i(id_branch), .id_jump_taken_i(id_jt),
    .ex_memread_i(ex_memread), .ex_regwrite_i(ex_regwrite), .ex_rd_i(ex_rd),
    .mem_memread_i(mem_memread), .mem_rd_i(mem_rd),
    .dmem_req_i(dmem_req), .dmem_ready_i(dmem_ready),
    .pc_write_o(pc_write), .ifid_write_o(ifid_write), .ifid_flush_o(ifid_flush),
    .idex_bubble_o(idex_bubble), .backend_hold_o(backend_hold),
    .wd_error_o(wd_error), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pipe status as plain flags and integers
  bit m_waiting, m_halted, m_wd;
  int m_waited, m_stalls, m_flushes;
  bit e_pw, e_iw, e_fl, e_bub, e_hold;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit uses(input logic [4:0] rd);
    return (rd != 0) && (rd == id_rs || rd == id_rt);
  endfunction

  task automatic model_reset();
    m_waiting = 0; m_halted = 0; m_wd = 0;
    m_waited = 0; m_stalls = 0; m_flushes = 0;
  endtask

  task automatic model_outputs();
    bit hazard;
    hazard = (ex_memread && uses(ex_rd)) ||
             (id_branch && ex_regwrite && uses(ex_rd)) ||
             (id_branch && mem_memread && uses(mem_rd));
    {e_pw, e_iw, e_fl, e_bub, e_hold} = '0;
    if (rst) ;
    else if (m_halted || m_waiting || (dmem_req && !dmem_ready)) e_hold = 1;
    else if (hazard) e_bub = 1;
    else begin
      e_pw = 1; e_iw = 1; e_fl = id_jt;
    end
  endtask

  task automatic model_clock();
    if (rst) begin
      model_reset();
      return;
    end
    if (!e_pw) m_stalls  = (m_stalls  < CMAX) ? m_stalls + 1  : CMAX;
    if (e_fl)  m_flushes = (m_flushes < CMAX) ? m_flushes + 1 : CMAX;
    if (m_halted) ;
    else if (m_waiting) begin
      if (dmem_ready) begin m_waiting = 0; m_waited = 0; end
      else if (m_waited == MAX_WAIT) begin m_waiting = 0; m_halted = 1; m_wd = 1; end
      else m_waited++;
    end else if (dmem_req && !dmem_ready) begin
      m_waiting = 1; m_waited = 1;
    end
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ".pc_write"},     int'(pc_write),     int'(e_pw));
    chk({ctx, ".ifid_write"},   int'(ifid_write),   int'(e_iw));
    chk({ctx, ".ifid_flush"},   int'(ifid_flush),   int'(e_fl));
    chk({ctx, ".idex_bubble"},  int'(idex_bubble),  int'(e_bub));
    chk({ctx, ".backend_hold"}, int'(backend_hold), int'(e_hold));
  endtask

  task automatic check_regs(input string ctx);
    chk({ctx, ".stall_cnt"}, int'(stall_cnt), m_stalls);
    chk({ctx, ".flush_cnt"}, int'(flush_cnt), m_flushes);
    chk({ctx, ".wd_error"},  int'(wd_error),  int'(m_wd));
  endtask

  // One cycle: inputs already applied; check combinational outputs mid-cycle,
  // advance the model on the edge, then check registered state.
  task automatic step(input string ctx);
    @(negedge clk);
    model_outputs();
    check_outputs(ctx);
    @(posedge clk);
    model_clock();
    #1;
    check_regs(ctx);
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; ex_rd = 0; mem_rd = 0;
    id_branch = 0; id_jt = 0; ex_memread = 0; ex_regwrite = 0; mem_memread = 0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    model_reset();
    step("reset");
    rst = 0;
  endtask

  initial begin
    rst = 1;
    idle();
    model_reset();
    #1;
    step("reset_state");
    rst = 0;
    step("idle_run");

    // Load-use: one stall cycle, then the pipe moves again
    do_reset();
    ex_memread = 1; ex_regwrite = 1; ex_rd = 2; id_rs = 2; id_rt = 7;
    step("lu_stall");
    chk("lu_stall_count", int'(stall_cnt), 1);
    idle(); id_rs = 2; id_rt = 7;
    step("lu_release");
    chk("lu_release_pc", int'(pc_write), 1);

    // Branch after load: br_ex stall, br_mem stall, then the taken flush
    do_reset();
    id_branch = 1; id_jt = 1; id_rs = 3; id_rt = 5;
    ex_memread = 1; ex_regwrite = 1; ex_rd = 3;
    step("br_ex");
    ex_memread = 0; ex_regwrite = 0; ex_rd = 0; mem_memread = 1; mem_rd = 3;
    step("br_mem");
    mem_memread = 0; mem_rd = 0;
    step("br_flush");
    chk("br_flush_count", int'(flush_cnt), 1);
    chk("br_stall_count", int'(stall_cnt), 2);
    idle();

    // $0 destination never stalls
    do_reset();
    ex_memread = 1; ex_regwrite = 1; ex_rd = 0; id_rs = 0; id_rt = 0;
    step("reg0");
    chk("reg0_pc", int'(pc_write), 1);
    idle();

    // Memory wait of three cycles, then ready
    do_reset();
    dmem_req = 1; dmem_ready = 0;
    repeat (3) step("mwait");
    dmem_ready = 1;
    step("mwait_ready");
    idle();
    step("mwait_after");
    chk("mwait_stalls", int'(stall_cnt), 4);
    chk("mwait_wd", int'(wd_error), 0);

    // Watchdog: memory never answers
    do_reset();
    dmem_req = 1; dmem_ready = 0;
    repeat (5) step("wd_wait");
    chk("wd_trip", int'(wd_error), 1);
    idle(); dmem_ready = 1;
    repeat (3) step("wd_halt");
    chk("wd_sticky", int'(wd_error), 1);
    chk("wd_halt_pc", int'(pc_write), 0);
    do_reset();
    chk("wd_clear_err", int'(wd_error), 0);
    chk("wd_clear_stall", int'(stall_cnt), 0);
    idle();

    // Asynchronous reset while waiting on memory
    dmem_req = 1; dmem_ready = 0;
    step("ar_wait");
    step("ar_wait2");
    @(negedge clk);
    #2;
    rst = 1;
    #1;
    chk("ar_hold", int'(backend_hold), 0);
    chk("ar_pc", int'(pc_write), 0);
    chk("ar_stall", int'(stall_cnt), 0);
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    idle();
    step("ar_after");

    // Stall counter saturation
    do_reset();
    ex_memread = 1; ex_rd = 4; id_rt = 4;
    repeat (20) step("sat");
    chk("sat_value", int'(stall_cnt), CMAX);
    idle();

    // Randomized traffic with occasional resets
    do_reset();
    for (int n = 0; n < 400; n++) begin
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      mem_rd      = 5'($urandom_range(0, 3));
      id_branch   = ($urandom_range(0, 2) == 0);
      id_jt       = ($urandom_range(0, 3) == 0);
      ex_memread  = ($urandom_range(0, 2) == 0);
      ex_regwrite = ($urandom_range(0, 1) == 0);
      mem_memread = ($urandom_range(0, 2) == 0);
      dmem_req    = ($urandom_range(0, 3) == 0);
      dmem_ready  = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 63) == 0) do_reset();
      else step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
